// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction fetch slice.
// Fetch FSM states and the fetched-instruction bundle.
package rv_fetch_pkg;

  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry skid FIFO between memory return and decode.
// Entry 0 is always the head; pops shift entry 1 down.
module fetch_buffer
  import rv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0, e1;
  fetch_entry_t n0, n1;
  logic [1:0]   cnt, nc;

  // Next contents: flush wins, else pop then push.
  always_comb begin
    n0 = e0;
    n1 = e1;
    nc = cnt;
    if (flush) begin
      nc = 2'd0;
    end else begin
      if (pop && cnt != 2'd0) begin
        n0 = e1;
        nc = cnt - 2'd1;
      end
      if (push && nc != 2'd2) begin
        if (nc == 2'd0) n0 = din;
        else            n1 = din;
        nc = nc + 2'd1;
      end
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      e0  <= n0;
      e1  <= n1;
      cnt <= nc;
    end
  end

  assign head  = e0;
  assign count = cnt;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, 1-cycle memory tracking, skid buffer.
// Redirects flush in-flight work; bad PCs park in FAULT.
module ifetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_AW,
  parameter int DATA_WIDTH = FETCH_DW,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int MEM_BYTES = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_pc
);

  localparam logic [ADDR_WIDTH-1:0] PC_MAX =
    ADDR_WIDTH'(MEM_BYTES - PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(PC_STEP);

  function automatic logic pc_legal(
    input logic [ADDR_WIDTH-1:0] pc
  );
    return (pc[1:0] == 2'b00) && (pc <= PC_MAX);
  endfunction

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic                  pop, push, issue;
  logic                  pc_ok, redir_ok;
  fetch_entry_t          din, head;

  assign pc_ok    = pc_legal(fetch_pc);
  assign redir_ok = pc_legal(redirect_pc);
  assign pop      = out_valid & out_ready;
  assign push     = inflight & ~redirect_valid;
  assign occ      = {1'b0, count} + {2'b00, inflight}
                  - {2'b00, pop};
  assign issue    = (state == FETCH_RUN) & ~redirect_valid
                  & pc_ok & (occ < 3'd2);

  assign din.instr = imem_instr;
  assign din.pc    = inflight_pc;

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // PC, in-flight tracking and RUN/FAULT control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      if (redir_ok) begin
        state <= FETCH_RUN;
        fault <= 1'b0;
      end else begin
        state    <= FETCH_FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + STEP;
      end
      if (state == FETCH_RUN && !pc_ok && !inflight) begin
        state    <= FETCH_FAULT;
        fault    <= 1'b1;
        fault_pc <= fetch_pc;
      end
    end
  end

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random
// ready/redirect traffic against an in-order PC stream model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [512];

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory with a 1-cycle registered read.
  always @(posedge clk) imem_instr <= mem[imem_addr[10:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 ||
        out_instr !== 32'h0 || fault !== 1'b0 ||
        fault_pc !== 32'h0 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: valid=%0b pc=%h instr=%h fault=%0b fpc=%h addr=%h, required all 0",
               out_valid, out_pc, out_instr, fault, fault_pc, imem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_c0: valid=%0b required 0", out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_c1: valid=%0b required 0", out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
        out_instr !== 32'h0000_0013) begin
      n_bad++;
      $display("FAIL first_c2: valid=%0b pc=%h instr=%h required 1/0/00000013",
               out_valid, out_pc, out_instr);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 ||
        out_instr !== 32'h0010_0093) begin
      n_bad++;
      $display("FAIL first_c3: valid=%0b pc=%h instr=%h required 1/4/00100093",
               out_valid, out_pc, out_instr);
    end
    exp = 32'h8;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== exp ||
          out_instr !== mem[exp[10:2]]) begin
        n_bad++;
        $display("FAIL stream: valid=%0b pc=%h instr=%h required pc=%h instr=%h",
                 out_valid, out_pc, out_instr, exp, mem[exp[10:2]]);
      end
      exp += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL bp_first: valid=%0b pc=%h required 1/0",
               out_valid, out_pc);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
          out_instr !== mem[0] || imem_addr !== 32'h8) begin
        n_bad++;
        $display("FAIL bp_hold: valid=%0b pc=%h instr=%h addr=%h required 1/0/%h/8",
                 out_valid, out_pc, out_instr, imem_addr, mem[0]);
      end
    end
    out_ready = 1'b1;
    exp = 32'h0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== exp ||
          out_instr !== mem[exp[10:2]]) begin
        n_bad++;
        $display("FAIL bp_drain: valid=%0b pc=%h instr=%h required pc=%h",
                 out_valid, out_pc, out_instr, exp);
      end
      exp += 32'd4;
      step();
    end
  endtask

  task automatic redirect_and_check(input logic [31:0] tgt,
                                    input string tag);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_flush: valid=%0b pc=%h required valid 0",
               tag, out_valid, out_pc);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_gap: valid=%0b pc=%h required valid 0",
               tag, out_valid, out_pc);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== tgt ||
        out_instr !== mem[tgt[10:2]]) begin
      n_bad++;
      $display("FAIL %s_target: valid=%0b pc=%h instr=%h required pc=%h instr=%h",
               tag, out_valid, out_pc, out_instr, tgt, mem[tgt[10:2]]);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] tgt;
    logic [31:0] exp;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    redirect_and_check(32'h40, "redir");
    exp = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== exp) begin
        n_bad++;
        $display("FAIL redir_stream: valid=%0b pc=%h required pc=%h",
                 out_valid, out_pc, exp);
      end
      exp += 32'd4;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tgt = 32'($urandom_range(0, 400)) << 2;
    redirect_and_check(tgt, "redir_full");
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'h42 ||
        out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_set: fault=%0b fpc=%h valid=%0b required 1/42/0",
               fault, fault_pc, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fault_park: fault=%0b valid=%0b required 1/0",
                 fault, out_valid);
      end
    end
    redirect_and_check(32'h10, "fault_exit");
    n_cmp++;
    if (fault !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_clear: fault=%0b required 0", fault);
    end
  endtask

  task automatic test_end_of_mem();
    redirect_and_check(32'h7F8, "eom");
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h7FC ||
        out_instr !== mem[511] || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL eom_last: valid=%0b pc=%h fault=%0b required 1/7fc/0",
               out_valid, out_pc, fault);
    end
    step();
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'h800 ||
        out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL eom_fault: fault=%0b fpc=%h valid=%0b required 1/800/0",
               fault, fault_pc, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL mid_full: valid=%0b pc=%h required 1/100",
               out_valid, out_pc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 ||
        fault !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%0b addr=%h fault=%0b required 0/0/0",
               out_valid, imem_addr, fault);
    end
    out_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
        out_instr !== mem[0]) begin
      n_bad++;
      $display("FAIL mid_restart: valid=%0b pc=%h required 1/0",
               out_valid, out_pc);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL mid_restart2: valid=%0b pc=%h required 1/4",
               out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [31:0] tgt;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    bit          stalled;
    bit          redir_prev;
    int          pops;
    out_ready = 1'b1;
    do_reset();
    exp = 32'h0;
    stalled = 1'b0;
    redir_prev = 1'b0;
    pops = 0;
    for (int c = 0; c < 400; c++) begin
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== hold_pc ||
            out_instr !== hold_instr) begin
          n_bad++;
          $display("FAIL rnd_hold: valid=%0b pc=%h instr=%h required pc=%h instr=%h",
                   out_valid, out_pc, out_instr, hold_pc, hold_instr);
        end
      end
      if (redir_prev) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_flush: valid=%0b pc=%h required valid 0",
                   out_valid, out_pc);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (out_pc !== exp || out_instr !== mem[exp[10:2]]) begin
          n_bad++;
          $display("FAIL rnd_order: pc=%h instr=%h required pc=%h instr=%h",
                   out_pc, out_instr, exp, mem[exp[10:2]]);
        end
        exp += 32'd4;
        pops++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      hold_pc = out_pc;
      hold_instr = out_instr;
      redirect_valid = 1'b0;
      redir_prev = 1'b0;
      if ($urandom_range(0, 19) == 0 || exp > 32'h700) begin
        tgt = 32'($urandom_range(0, 400)) << 2;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        exp = tgt;
        stalled = 1'b0;
        redir_prev = 1'b1;
      end
      step();
    end
    redirect_valid = 1'b0;
    n_cmp++;
    if (pops < 100) begin
      n_bad++;
      $display("FAIL rnd_progress: pops=%0d required >= 100", pops);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_fault();
    test_end_of_mem();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
